fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the processor: holds the program counter, issues one instruction-memory read at a time, and presents the fetched instruction with its PC to decode. It sits directly downstream of the branch/jump controller, consuming that block's `select`/`addressout` pair as a redirect. It also supplies PC+4 for link-register writes (jrsal).

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `redirect_valid` in 1: branch/jump taken (driven by brjmpcont `select`).
- `redirect_addr` in 32: target (brjmpcont `addressout`); bits [1:0] ignored and forced to 0.
- `imem_req_valid` out 1: read request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: read address; always equals the internal `pc`.
- `imem_rsp_valid` in 1: read data valid, one cycle pulse.
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: instruction held for decode.
- `inst_ready` in 1: decode accepts it.
- `inst_data` out 32: instruction word.
- `inst_pc` out 32: address of `inst_data`.
- `inst_pc_plus4` out 32: `inst_pc + 4`, mod 2^32.

## Operation
- FSM states:
  - IDLE: reset state; goes to FETCH next cycle unconditionally.
  - FETCH: `imem_req_valid`=1. On `imem_req_ready`, go to WAIT.
  - WAIT: at most one request outstanding. On `imem_rsp_valid`, capture the response and go to FULL, or discard it and go to FETCH if `kill` is set.
  - FULL: `inst_valid`=1. On `inst_ready`, go to FETCH.
- Capture on a non-killed response:
  - `inst_data`←`imem_rsp_data`.
  - `inst_pc`←`pc`, `inst_pc_plus4`←`pc+4`.
  - `pc`←`pc+4`, wrapping 32'hFFFF_FFFC→0.
- Redirect has priority over every other update, in every state except IDLE:
  - `pc`←{`redirect_addr`[31:2],2'b00}.
  - FETCH, no handshake this cycle: stay in FETCH. The request address changes next cycle; memory must tolerate an address change while valid only in this case.
  - FETCH, handshake this same cycle: the old-`pc` request is in flight. Go to WAIT with `kill`=1.
  - WAIT: set `kill`=1. If the response arrives in the same cycle, discard it and go to FETCH.
  - FULL: drop the held instruction and go to FETCH. A simultaneous `inst_ready` is not a valid handshake; decode squashes on redirect.
- `kill` clears whenever a response is consumed or discarded.
- A redirect in IDLE is ignored.
- `imem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset, while `rst_n`=0 at an edge:
  - state IDLE, `pc`=`RESET_PC`, `kill`=0.
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst_data`/`inst_pc`/`inst_pc_plus4`=0.
- Reset mid-operation aborts any outstanding request. A later response is ignored because state is not WAIT.
- `imem_req_valid` and `inst_valid` are decoded from registered state; no combinational input→output path.
- First request: cycle 2 after the reset-release edge (IDLE, then FETCH).
- Best-case throughput, zero-wait memory (ready=1, response one cycle after accept, decode ready): one instruction per 3 cycles (FETCH→WAIT→FULL).
- Redirect-to-new-request latency:
  - 1 cycle from FETCH or FULL.
  - From WAIT: 1 cycle after the killed response.

## Structure
- Shared package `fetch_pkg`:
  - state encoding (IDLE, FETCH, WAIT, FULL as 2-bit localparams);
  - `INSN_W`=32, `PC_INC`=4.
- One sub-module `pc_reg`: the 32-bit PC register.
  - Inputs: reset value, load (redirect), increment.
  - Priority: reset > load > increment.
  - Load forces bits [1:0] to 0.
- Everything else is inline in `fetch_unit`.

## Test plan
- Reset release with `RESET_PC`=0x100, zero-wait memory returning 0xAAAA0000|addr -> decode sees pc 0x100, 0x104, 0x108 with matching data; `inst_pc_plus4`=pc+4.
- `inst_ready` held low for 5 cycles in FULL -> `inst_valid`, `inst_data` and `inst_pc` stable; no new `imem_req_valid` until accepted.
- Redirect to 0x2003 while in WAIT (response 3 cycles late) -> late response discarded, next request to 0x2000, decode's next pc = 0x2000.
- Redirect asserted in FULL together with `inst_ready` -> held instruction dropped, next `imem_req_addr`=target, no `pc+4` fetch issued.
- Redirect to 0xFFFF_FFFC -> fetch at 0xFFFF_FFFC; `inst_pc_plus4`=0; next fetch address 0x0000_0000.
- `rst_n` low for 1 cycle while in WAIT -> outputs at reset values, straggling `imem_rsp_valid` ignored, refetch from `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          INSN_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_FETCH = S_FETCH,
        ST_WAIT  = S_WAIT,
        ST_FULL  = S_FULL
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: reset value, word-aligned load, sequential increment.
// Latency: new value visible the cycle after the update edge.
// Backpressure: none; the caller decides when to load or increment.
module pc_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] reset_val,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic        inc,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= reset_val;
        end else if (load) begin
            pc <= load_addr & ~32'h3;
        end else if (inc) begin
            pc <= pc + PC_INC;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, holds one instruction for decode.
// Latency: 3 cycles per instruction with zero-wait memory and a ready decoder.
// Backpressure: stalls in FULL until inst_ready; never issues a new request meanwhile.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_addr,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INSN_W-1:0] inst_data,
    output logic [31:0]       inst_pc,
    output logic [31:0]       inst_pc_plus4
);

    fetch_state_t state;
    logic         kill;
    logic [31:0]  pc;
    logic         redirect_take;
    logic         rsp_take;

    // Redirects are meaningless before the first fetch has been armed.
    assign redirect_take = redirect_valid && (state != ST_IDLE);
    assign rsp_take      = (state == ST_WAIT) && imem_rsp_valid && !kill && !redirect_valid;

    pc_reg u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .reset_val (RESET_PC),
        .load      (redirect_take),
        .load_addr (redirect_addr),
        .inc       (rsp_take),
        .pc        (pc)
    );

    assign imem_req_valid = (state == ST_FETCH);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == ST_FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            kill          <= 1'b0;
            inst_data     <= '0;
            inst_pc       <= '0;
            inst_pc_plus4 <= '0;
        end else begin
            if (rsp_take) begin
                inst_data     <= imem_rsp_data;
                inst_pc       <= pc;
                inst_pc_plus4 <= pc + PC_INC;
            end
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    // A redirect racing the accept leaves a stale request in flight.
                    if (imem_req_ready) begin
                        state <= ST_WAIT;
                        kill  <= redirect_valid;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        kill  <= 1'b0;
                        state <= (kill || redirect_valid) ? ST_FETCH : ST_FULL;
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (redirect_valid || inst_ready) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory model.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          hold;
        logic [31:0] pc;
        logic [31:0] data;
    } vec_t;

    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          mem_lat = 1;
    int          cnt    = 0;
    logic        pend   = 1'b0;
    logic [31:0] pend_addr = '0;
    int          last_det = 0;
    logic [31:0] req_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: log handshakes, advance the memory model, settle 1ns after the edge.
    task automatic cycle();
        logic        hs;
        logic [31:0] a;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) req_log.push_back(a);
        imem_rsp_valid = 1'b0;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = a;
            cnt       = mem_lat - 1;
        end else if (pend && cnt > 0) begin
            cnt--;
        end
        if (pend && cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hAAAA_0000 | pend_addr;
            pend           = 1'b0;
        end
    endtask

    task automatic wait_inst(input string name, input logic [31:0] epc, input logic [31:0] edata);
        bit seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            cycle();
            if (inst_valid) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: inst_valid got 0 expected 1", name);
        end else begin
            last_det = cyc;
            chk({name, " inst_pc"}, inst_pc, epc);
            chk({name, " inst_data"}, inst_data, edata);
            chk({name, " inst_pc_plus4"}, inst_pc_plus4, epc + 32'd4);
        end
    endtask

    task automatic hold_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        cycle();
        cycle();
        pend           = 1'b0;
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        int prev_t;
        int prev_hold;
        vecs[0] = '{lat: 1, hold: 0, pc: 32'h100, data: 32'hAAAA_0100};
        vecs[1] = '{lat: 1, hold: 0, pc: 32'h104, data: 32'hAAAA_0104};
        vecs[2] = '{lat: 1, hold: 5, pc: 32'h108, data: 32'hAAAA_0108};
        vecs[3] = '{lat: 2, hold: 0, pc: 32'h10C, data: 32'hAAAA_010C};
        vecs[4] = '{lat: 3, hold: 1, pc: 32'h110, data: 32'hAAAA_0110};
        imem_rsp_data  = '0;
        imem_rsp_valid = 1'b0;

        // Reset values and first request timing.
        hold_reset();
        chk("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst req_addr", imem_req_addr, RPC);
        chk("rst inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst inst_data", inst_data, 32'd0);
        chk("rst inst_pc", inst_pc, 32'd0);
        chk("rst inst_pc_plus4", inst_pc_plus4, 32'd0);
        rst_n = 1'b1;
        prev_t    = cyc;
        prev_hold = 0;
        chk("idle req_valid", {31'b0, imem_req_valid}, 32'd0);
        cycle();
        chk("first req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first req_addr", imem_req_addr, RPC);
        prev_t = cyc - 1;

        // Sequential stream with varying memory latency and decode stalls.
        for (int i = 0; i < 5; i++) begin
            mem_lat = vecs[i].lat;
            wait_inst($sformatf("vec%0d", i), vecs[i].pc, vecs[i].data);
            chk($sformatf("vec%0d latency", i), last_det - prev_t, 2 + prev_hold + vecs[i].lat);
            if (vecs[i].hold > 0) begin
                inst_ready = 1'b0;
                for (int h = 0; h < vecs[i].hold; h++) begin
                    cycle();
                    chk($sformatf("vec%0d hold%0d inst_valid", i, h), {31'b0, inst_valid}, 32'd1);
                    chk($sformatf("vec%0d hold%0d inst_pc", i, h), inst_pc, vecs[i].pc);
                    chk($sformatf("vec%0d hold%0d inst_data", i, h), inst_data, vecs[i].data);
                    chk($sformatf("vec%0d hold%0d req_valid", i, h), {31'b0, imem_req_valid}, 32'd0);
                end
                inst_ready = 1'b1;
            end
            prev_t    = last_det;
            prev_hold = vecs[i].hold;
        end

        // Redirect while waiting on a slow response.
        hold_reset();
        rst_n   = 1'b1;
        mem_lat = 3;
        cycle();
        cycle();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_2003;
        cycle();
        redirect_valid = 1'b0;
        chk("wait-redir req_valid", {31'b0, imem_req_valid}, 32'd0);
        cycle();
        chk("wait-redir late rsp pending", {31'b0, imem_req_valid}, 32'd0);
        mem_lat = 1;
        cycle();
        chk("wait-redir req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("wait-redir req_addr", imem_req_addr, 32'h0000_2000);
        wait_inst("wait-redir", 32'h0000_2000, 32'hAAAA_2000);

        // Redirect in FULL together with inst_ready.
        hold_reset();
        rst_n      = 1'b1;
        inst_ready = 1'b0;
        wait_inst("full-redir first", RPC, 32'hAAAA_0100);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_3000;
        inst_ready     = 1'b1;
        req_log.delete();
        cycle();
        redirect_valid = 1'b0;
        chk("full-redir inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("full-redir req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("full-redir req_addr", imem_req_addr, 32'h0000_3000);
        wait_inst("full-redir", 32'h0000_3000, 32'hAAAA_3000);
        chk("full-redir req count", req_log.size(), 32'd1);
        if (req_log.size() > 0) chk("full-redir req0", req_log[0], 32'h0000_3000);

        // Redirect to top of address space from FETCH without handshake.
        hold_reset();
        rst_n = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("wrap req_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_inst("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        chk("wrap plus4 zero", inst_pc_plus4, 32'd0);
        cycle();
        chk("wrap next req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("wrap next req_addr", imem_req_addr, 32'd0);

        // Redirect in FETCH on the same cycle as the accept.
        hold_reset();
        rst_n = 1'b1;
        cycle();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_4000;
        cycle();
        redirect_valid = 1'b0;
        chk("fetch-hs-redir req_valid", {31'b0, imem_req_valid}, 32'd0);
        cycle();
        chk("fetch-hs-redir req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("fetch-hs-redir req_addr", imem_req_addr, 32'h0000_4000);
        wait_inst("fetch-hs-redir", 32'h0000_4000, 32'hAAAA_4000);

        // One-cycle reset during WAIT with a straggling response.
        mem_lat = 3;
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("midrst req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("midrst req_addr", imem_req_addr, RPC);
        chk("midrst inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("midrst inst_data", inst_data, 32'd0);
        chk("midrst inst_pc", inst_pc, 32'd0);
        chk("midrst inst_pc_plus4", inst_pc_plus4, 32'd0);
        rst_n   = 1'b1;
        mem_lat = 1;
        cycle();
        chk("midrst refetch addr", imem_req_addr, RPC);
        wait_inst("midrst refetch", RPC, 32'hAAAA_0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
